mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; data width 32, address width 32, strobe width 4 are fixed.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 imem_in  input  mem_in_type  fetch request: mem_valid, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0].
REQ-005 imem_out  output  mem_out_type  fetch response: mem_ready, mem_rdata[31:0].
REQ-006 dmem_in  input  mem_in_type  load/store request from decode stage.
REQ-007 dmem_out  output  mem_out_type  load/store response.
REQ-008 mem_in  output  mem_in_type  shared memory port request.
REQ-009 mem_out  input  mem_out_type  shared memory port response.
REQ-010 err  output  1  sticky protocol-violation flag.

Function
REQ-011 Requests are single-cycle pulses on X_in.mem_valid; the arbiter SHALL capture each pulse, with addr/wdata/wstrb/instr, into a one-deep pending slot per requester (I, D) at the clock edge.
REQ-012 States: IDLE, BUSY_I, BUSY_D; owner = requester of the in-flight transaction.
REQ-013 IDLE: if D pending -> issue D, go BUSY_D; else if I pending -> issue I, go BUSY_I; else stay IDLE.
REQ-014 Priority: D strictly over I whenever both pending at a grant decision.
REQ-015 Issue: mem_in.mem_valid = 1 for exactly one cycle, the cycle after the grant edge; mem_addr/mem_wdata/mem_wstrb/mem_instr SHALL hold the owner's captured values from that cycle until the mem_ready cycle inclusive.
REQ-016 Minimum latency: request pulse in cycle N -> mem_in.mem_valid in cycle N+1.
REQ-017 mem_in.mem_instr SHALL be 1 for I transactions and 0 for D transactions, regardless of the captured field.
REQ-018 BUSY_x: on mem_out.mem_ready = 1, X_out.mem_ready = 1 and X_out.mem_rdata = mem_out.mem_rdata in the same cycle (combinational); non-owner mem_ready = 0; owner's pending slot cleared; state -> IDLE.
REQ-019 mem_ready may arrive in the same cycle as mem_valid; it SHALL complete the transaction.
REQ-020 Back-to-back: pending request of the other requester at the ready edge SHALL be issued with mem_valid in the cycle after ready (one idle gap at most).
REQ-021 A pulse arriving in the same cycle as a grant decision is captured but not eligible until the next decision.
REQ-022 mem_out.mem_ready in IDLE SHALL be ignored: no X_out.mem_ready, no state change.
REQ-023 New pulse from a requester whose slot is occupied or in flight: request dropped, err set to 1 until reset; in-flight transaction unaffected.
REQ-024 X_out.mem_rdata SHALL be 0 whenever X_out.mem_ready = 0.

Reset
REQ-025 rst = 0 at an edge: state IDLE, both slots empty, err = 0.
REQ-026 During and after reset: mem_in all fields 0, imem_out/dmem_out all fields 0.
REQ-027 Reset mid-transaction abandons it; a later mem_ready SHALL be ignored per REQ-022.

Verification
REQ-028 I pulse addr 0x00000100 cycle 5, ready cycle 8 rdata 0x00000013 -> mem_valid cycle 6 only, mem_instr=1, imem_out.mem_ready cycle 8 with 0x00000013, dmem_out idle.
REQ-029 I and D pulses same cycle (I 0x200, D store 0x80000004 wdata 0xDEADBEEF wstrb 0xF), ready after 2 cycles each -> D issued first with mem_wstrb=0xF, I issued cycle after D ready.
REQ-030 Same-cycle ready: memory asserts mem_ready with mem_valid for D load 0x1000 -> dmem_out.mem_ready in that cycle, next pending I issued following cycle.
REQ-031 Second D pulse while D in flight -> err=1 next cycle, only one D transaction on mem_in, err stays 1 until rst.
REQ-032 rst=0 while BUSY_I, then mem_ready pulse after release -> all outputs 0, imem_out.mem_ready never asserted, new request served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (fetch I / load-store D) arbiter onto one shared memory port, D has priority.
// Issue one cycle after the request pulse; ready is passed back combinationally; one pending slot per requester.
package mem_arbiter_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t     state, state_nxt;
  mem_in_type slot_i, slot_d;
  logic       slot_i_v, slot_d_v;
  logic       issue_q, issue_nxt;
  logic       done_i, done_d;

  // An idle decision sees the pulse arriving this cycle; the decision at a
  // ready edge only sees slots captured before that cycle.
  always_comb begin
    state_nxt = state;
    issue_nxt = 1'b0;
    done_i    = 1'b0;
    done_d    = 1'b0;
    imem_out  = '0;
    dmem_out  = '0;
    mem_in    = '0;
    case (state)
      IDLE: begin
        if (slot_d_v || dmem_in.mem_valid) begin
          state_nxt = BUSY_D;
          issue_nxt = 1'b1;
        end else if (slot_i_v || imem_in.mem_valid) begin
          state_nxt = BUSY_I;
          issue_nxt = 1'b1;
        end
      end
      BUSY_I: begin
        mem_in           = slot_i;
        mem_in.mem_valid = issue_q;
        mem_in.mem_instr = 1'b1;
        if (mem_out.mem_ready) begin
          imem_out = mem_out;
          done_i   = 1'b1;
          if (slot_d_v) begin
            state_nxt = BUSY_D;
            issue_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      BUSY_D: begin
        mem_in           = slot_d;
        mem_in.mem_valid = issue_q;
        mem_in.mem_instr = 1'b0;
        if (mem_out.mem_ready) begin
          dmem_out = mem_out;
          done_d   = 1'b1;
          if (slot_i_v) begin
            state_nxt = BUSY_I;
            issue_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are forced quiet while reset is held, not just after its edge.
    if (!rst) begin
      imem_out = '0;
      dmem_out = '0;
      mem_in   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      issue_q  <= 1'b0;
      slot_i   <= '0;
      slot_d   <= '0;
      slot_i_v <= 1'b0;
      slot_d_v <= 1'b0;
      err      <= 1'b0;
    end else begin
      state   <= state_nxt;
      issue_q <= issue_nxt;
      if (done_i) slot_i_v <= 1'b0;
      if (done_d) slot_d_v <= 1'b0;
      // A slot stays occupied until its transaction completes, so this also
      // catches a repeat pulse while that requester is in flight.
      if (imem_in.mem_valid) begin
        if (slot_i_v) begin
          err <= 1'b1;
        end else begin
          slot_i_v <= 1'b1;
          slot_i   <= imem_in;
        end
      end
      if (dmem_in.mem_valid) begin
        if (slot_d_v) begin
          err <= 1'b1;
        end else begin
          slot_d_v <= 1'b1;
          slot_d   <= dmem_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  mem_in_type  imem_in, dmem_in, mem_in;
  mem_out_type imem_out, dmem_out, mem_out;
  logic        err;
  int          n_checks = 0;
  int          n_fail = 0;
  int          vld_cnt = 0;
  int          vld_base;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .imem_in(imem_in), .imem_out(imem_out),
    .dmem_in(dmem_in), .dmem_out(dmem_out),
    .mem_in(mem_in), .mem_out(mem_out),
    .err(err)
  );

  always #5 clk = ~clk;

  // Counts issue cycles seen on the shared port.
  always @(posedge clk) if (mem_in.mem_valid) vld_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_in = '0;
    dmem_in = '0;
    mem_out = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    step();
    step();
    @(negedge clk);
    n_checks++; if (mem_in !== '0) begin n_fail++; $display("FAIL reset_mem_in: got %h expected 0", mem_in); end
    n_checks++; if (imem_out !== '0) begin n_fail++; $display("FAIL reset_imem_out: got %h expected 0", imem_out); end
    n_checks++; if (dmem_out !== '0) begin n_fail++; $display("FAIL reset_dmem_out: got %h expected 0", dmem_out); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_i();
    step();
    imem_in = '{mem_valid: 1'b1, mem_instr: 1'b1, mem_addr: 32'h100, mem_wdata: 32'h0, mem_wstrb: 4'h0};
    @(negedge clk);
    n_checks++; if (mem_in.mem_valid !== 1'b0) begin n_fail++; $display("FAIL single_i_early_valid: got %b expected 0", mem_in.mem_valid); end
    step();
    imem_in = '0;
    @(negedge clk);
    n_checks++; if (mem_in.mem_valid !== 1'b1) begin n_fail++; $display("FAIL single_i_valid: got %b expected 1", mem_in.mem_valid); end
    n_checks++; if (mem_in.mem_instr !== 1'b1) begin n_fail++; $display("FAIL single_i_instr: got %b expected 1", mem_in.mem_instr); end
    n_checks++; if (mem_in.mem_addr !== 32'h100) begin n_fail++; $display("FAIL single_i_addr: got %h expected 00000100", mem_in.mem_addr); end
    step();
    @(negedge clk);
    n_checks++; if (mem_in.mem_valid !== 1'b0) begin n_fail++; $display("FAIL single_i_valid_once: got %b expected 0", mem_in.mem_valid); end
    n_checks++; if (mem_in.mem_addr !== 32'h100) begin n_fail++; $display("FAIL single_i_addr_hold: got %h expected 00000100", mem_in.mem_addr); end
    step();
    mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h13};
    @(negedge clk);
    n_checks++; if (imem_out !== {1'b1, 32'h13}) begin n_fail++; $display("FAIL single_i_resp: got %h expected 100000013", imem_out); end
    n_checks++; if (dmem_out !== '0) begin n_fail++; $display("FAIL single_i_dmem_idle: got %h expected 0", dmem_out); end
    step();
    mem_out = '0;
    @(negedge clk);
    n_checks++; if (mem_in !== '0) begin n_fail++; $display("FAIL single_i_back_idle: got %h expected 0", mem_in); end
    n_checks++; if (imem_out !== '0) begin n_fail++; $display("FAIL single_i_resp_clear: got %h expected 0", imem_out); end
  endtask

  task automatic test_priority();
    step();
    imem_in = '{mem_valid: 1'b1, mem_instr: 1'b1, mem_addr: 32'h200, mem_wdata: 32'h0, mem_wstrb: 4'h0};
    dmem_in = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_addr: 32'h80000004, mem_wdata: 32'hDEADBEEF, mem_wstrb: 4'hF};
    step();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (mem_in !== {1'b1, 1'b0, 32'h80000004, 32'hDEADBEEF, 4'hF}) begin n_fail++; $display("FAIL prio_d_first: got %h expected D store issue", mem_in); end
    step();
    step();
    mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h55};
    @(negedge clk);
    n_checks++; if (dmem_out !== {1'b1, 32'h55}) begin n_fail++; $display("FAIL prio_d_resp: got %h expected 100000055", dmem_out); end
    n_checks++; if (imem_out !== '0) begin n_fail++; $display("FAIL prio_i_quiet: got %h expected 0", imem_out); end
    step();
    mem_out = '0;
    @(negedge clk);
    n_checks++; if (mem_in !== {1'b1, 1'b1, 32'h200, 32'h0, 4'h0}) begin n_fail++; $display("FAIL prio_i_after_d: got %h expected I issue 0x200", mem_in); end
    step();
    step();
    mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h66};
    @(negedge clk);
    n_checks++; if (imem_out !== {1'b1, 32'h66}) begin n_fail++; $display("FAIL prio_i_resp: got %h expected 100000066", imem_out); end
    step();
    mem_out = '0;
  endtask

  task automatic test_same_cycle_ready();
    step();
    dmem_in = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_addr: 32'h1000, mem_wdata: 32'h0, mem_wstrb: 4'h0};
    imem_in = '{mem_valid: 1'b1, mem_instr: 1'b1, mem_addr: 32'h300, mem_wdata: 32'h0, mem_wstrb: 4'h0};
    step();
    clear_inputs();
    mem_out = '{mem_ready: 1'b1, mem_rdata: 32'hA5A5A5A5};
    @(negedge clk);
    n_checks++; if (mem_in.mem_valid !== 1'b1 || mem_in.mem_addr !== 32'h1000) begin n_fail++; $display("FAIL same_d_issue: got %h expected valid load 0x1000", mem_in); end
    n_checks++; if (dmem_out !== {1'b1, 32'hA5A5A5A5}) begin n_fail++; $display("FAIL same_d_resp: got %h expected 1a5a5a5a5", dmem_out); end
    n_checks++; if (imem_out !== '0) begin n_fail++; $display("FAIL same_i_quiet: got %h expected 0", imem_out); end
    step();
    mem_out = '0;
    @(negedge clk);
    n_checks++; if (mem_in !== {1'b1, 1'b1, 32'h300, 32'h0, 4'h0}) begin n_fail++; $display("FAIL same_i_next: got %h expected I issue 0x300", mem_in); end
    step();
    mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h3};
    @(negedge clk);
    n_checks++; if (imem_out !== {1'b1, 32'h3}) begin n_fail++; $display("FAIL same_i_resp: got %h expected 100000003", imem_out); end
    step();
    mem_out = '0;
  endtask

  task automatic test_idle_ready();
    step();
    mem_out = '{mem_ready: 1'b1, mem_rdata: 32'hFFFF0000};
    @(negedge clk);
    n_checks++; if (imem_out !== '0 || dmem_out !== '0) begin n_fail++; $display("FAIL idle_ready_ignored: got %h/%h expected 0/0", imem_out, dmem_out); end
    step();
    mem_out = '0;
    @(negedge clk);
    n_checks++; if (mem_in !== '0) begin n_fail++; $display("FAIL idle_ready_no_issue: got %h expected 0", mem_in); end
  endtask

  task automatic test_error();
    step();
    vld_base = vld_cnt;
    dmem_in = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_addr: 32'h40, mem_wdata: 32'h0, mem_wstrb: 4'h0};
    step();
    dmem_in = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_addr: 32'h44, mem_wdata: 32'h1, mem_wstrb: 4'h1};
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_not_yet: got %b expected 0", err); end
    step();
    dmem_in = '0;
    @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err); end
    n_checks++; if (mem_in.mem_addr !== 32'h40) begin n_fail++; $display("FAIL err_inflight_addr: got %h expected 00000040", mem_in.mem_addr); end
    step();
    mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h9};
    @(negedge clk);
    n_checks++; if (dmem_out !== {1'b1, 32'h9}) begin n_fail++; $display("FAIL err_inflight_resp: got %h expected 100000009", dmem_out); end
    step();
    mem_out = '0;
    step();
    step();
    @(negedge clk);
    n_checks++; if (vld_cnt - vld_base !== 1) begin n_fail++; $display("FAIL err_one_issue: got %0d expected 1", vld_cnt - vld_base); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_reset_mid();
    step();
    imem_in = '{mem_valid: 1'b1, mem_instr: 1'b1, mem_addr: 32'h500, mem_wdata: 32'h0, mem_wstrb: 4'h0};
    step();
    imem_in = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_in !== '0 || imem_out !== '0) begin n_fail++; $display("FAIL rst_mid_quiet: got %h/%h expected 0/0", mem_in, imem_out); end
    step();
    rst = 1'b1;
    mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h77};
    @(negedge clk);
    n_checks++; if (imem_out !== '0) begin n_fail++; $display("FAIL rst_mid_stale_ready: got %h expected 0", imem_out); end
    n_checks++; if (mem_in !== '0) begin n_fail++; $display("FAIL rst_mid_mem_in: got %h expected 0", mem_in); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err_clear: got %b expected 0", err); end
    step();
    mem_out = '0;
    imem_in = '{mem_valid: 1'b1, mem_instr: 1'b1, mem_addr: 32'h600, mem_wdata: 32'h0, mem_wstrb: 4'h0};
    step();
    imem_in = '0;
    mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h88};
    @(negedge clk);
    n_checks++; if (mem_in !== {1'b1, 1'b1, 32'h600, 32'h0, 4'h0}) begin n_fail++; $display("FAIL rst_mid_new_issue: got %h expected I issue 0x600", mem_in); end
    n_checks++; if (imem_out !== {1'b1, 32'h88}) begin n_fail++; $display("FAIL rst_mid_new_resp: got %h expected 100000088", imem_out); end
    step();
    mem_out = '0;
    @(negedge clk);
    n_checks++; if (imem_out !== '0 || mem_in !== '0) begin n_fail++; $display("FAIL rst_mid_done_idle: got %h/%h expected 0/0", imem_out, mem_in); end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_single_i();
    test_priority();
    test_same_cycle_ready();
    test_idle_ready();
    test_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
